// File: rtl/io_key_sw_responder.sv
// KEY/SW memory-mapped responder: 2-flop sync, per-group debounce, sticky ready/overrun status.
// Latency: loads return data one cycle after rdEn; pin-to-stable is 2 + 1 + (DEBOUNCE_CYCLES-1) + 1 cycles.
// Backpressure: none; the bus is always answered, dOut is 0 on non-hit cycles for OR-merging.
// Optional: define IO_KEY_SW_IRQ_EN to add the ie control bits and the registered irq output.

// Per-group debouncer: accepts a new value only after it has been steady for a full window.
module io_key_sw_debounce #(
   parameter int W               = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_BITS        = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_sync,
   output logic [W-1:0] o_next,
   output logic         o_chg
);
   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]        r_cand;
   logic [W-1:0]        r_stable;
   logic [CNT_BITS-1:0] r_cnt;
   logic                w_match;
   logic                w_sat;

   assign w_match = (i_sync == r_cand);
   assign w_sat   = (r_cnt >= CNT_MAX);
   // chg fires on the same edge that moves the candidate into stable
   assign o_chg   = w_match & w_sat & (r_cand != r_stable);
   // value stable will hold after this edge, so a same-cycle load sees the new value
   assign o_next  = o_chg ? r_cand : r_stable;

   // candidate tracking, saturating window counter and stable update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else if (!w_match) begin
         r_cand <= i_sync;
         r_cnt  <= '0;
      end else if (!w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (o_chg) begin
         r_stable <= r_cand;
      end
   end
endmodule

module io_key_sw_responder #(
   parameter int               DBITS           = 32,
   parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
   parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
   parameter int               DEBOUNCE_CYCLES = 10000,
   parameter int               CNT_BITS        = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             rdEn,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   output logic [DBITS-1:0] dOut,
   output logic             hit,
   input  logic [3:0]       key,
   input  logic [9:0]       sw
`ifdef IO_KEY_SW_IRQ_EN
   ,
   output logic             irq
`endif
);
   logic [3:0]       r_key_s1, r_key_s2;
   logic [9:0]       r_sw_s1, r_sw_s2;
   logic [3:0]       w_key_next;
   logic [9:0]       w_sw_next;
   logic             w_kchg, w_schg;
   logic             r_krdy, r_kovr, r_srdy, r_sovr;
   logic             w_kie, w_sie;
   logic             w_krclr, w_srclr, w_koclr, w_soclr;
   logic [DBITS-1:0] w_rdata;
   logic [DBITS-1:0] r_dout;
   logic             w_unused_din;

   assign w_unused_din = ^dIn;

   // two-flop synchronizers; KEY idles high so it resets to all-released
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_key_s1 <= 4'hF;
         r_key_s2 <= 4'hF;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end

   io_key_sw_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_key_db (
      .clk(clk), .reset(reset), .i_sync(~r_key_s2), .o_next(w_key_next), .o_chg(w_kchg));

   io_key_sw_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_sw_db (
      .clk(clk), .reset(reset), .i_sync(r_sw_s2), .o_next(w_sw_next), .o_chg(w_schg));

   assign hit = (addr == ADDR_KEY) | (addr == ADDR_SW) |
                (addr == ADDR_KCTRL) | (addr == ADDR_SCTRL);

   assign w_krclr = rdEn & (addr == ADDR_KEY);
   assign w_srclr = rdEn & (addr == ADDR_SW);
   assign w_koclr = wrtEn & (addr == ADDR_KCTRL) & ~dIn[2];
   assign w_soclr = wrtEn & (addr == ADDR_SCTRL) & ~dIn[2];

   // sticky status: a new change always sets ready; overrun flags a change while ready was unread
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_krdy <= 1'b0;
         r_kovr <= 1'b0;
         r_srdy <= 1'b0;
         r_sovr <= 1'b0;
      end else begin
         r_krdy <= w_kchg | (r_krdy & ~w_krclr);
         r_kovr <= (w_kchg & r_krdy & ~w_krclr) | (r_kovr & ~w_koclr);
         r_srdy <= w_schg | (r_srdy & ~w_srclr);
         r_sovr <= (w_schg & r_srdy & ~w_srclr) | (r_sovr & ~w_soclr);
      end
   end

`ifdef IO_KEY_SW_IRQ_EN
   logic r_kie, r_sie, r_irq;
   assign w_kie = r_kie;
   assign w_sie = r_sie;
   assign irq   = r_irq;

   // interrupt enables follow any store to CTRL; irq is a registered OR of enabled ready bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kie <= 1'b0;
         r_sie <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (wrtEn && (addr == ADDR_KCTRL)) r_kie <= dIn[8];
         if (wrtEn && (addr == ADDR_SCTRL)) r_sie <= dIn[8];
         r_irq <= (r_krdy & r_kie) | (r_srdy & r_sie);
      end
   end
`else
   assign w_kie = 1'b0;
   assign w_sie = 1'b0;
`endif

   // load data mux; CTRL reads show pre-store state, data reads show the post-edge stable value
   always_comb begin
      w_rdata = '0;
      if (addr == ADDR_KEY)
         w_rdata = {{(DBITS-4){1'b0}}, w_key_next};
      else if (addr == ADDR_SW)
         w_rdata = {{(DBITS-10){1'b0}}, w_sw_next};
      else if (addr == ADDR_KCTRL)
         w_rdata = {{(DBITS-9){1'b0}}, w_kie, 5'b0, r_kovr, 1'b0, r_krdy};
      else if (addr == ADDR_SCTRL)
         w_rdata = {{(DBITS-9){1'b0}}, w_sie, 5'b0, r_sovr, 1'b0, r_srdy};
   end

   // registered load data, forced to 0 when not addressed so it can be OR-merged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_dout <= '0;
      else if (rdEn && hit)
         r_dout <= w_rdata;
      else
         r_dout <= '0;
   end

   assign dOut = r_dout;
endmodule
